// File: rtl/divu32_if.sv
// divu32 request/result bundle: operands and start from the requester,
// quotient/remainder/status back from the divider.
interface divu32_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/divu32.sv
// divu32: sequential 32-bit unsigned restoring divider, one quotient bit
// per clock. Trial subtraction is an add of the complemented divisor with
// carry-in 1; the 33rd bit of that sum is the borrow. A zero divisor needs
// no special path: every trial succeeds, giving all-ones / dividend.
module divu32 (
  input  logic      clk,
  input  logic      reset,
  divu32_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  logic [31:0] dq_r;
  logic [31:0] dv_r;
  logic [31:0] rem_r;
  logic [4:0]  cnt_r;

  logic [31:0] shifted_s;
  logic [32:0] trial_s;
  logic [31:0] rem_step_s;
  logic [31:0] dq_step_s;
  logic        accept_s;
  logic        load_s;

  logic        busy_nxt_s;
  logic        done_nxt_s;
  logic        dbz_nxt_s;

  logic [31:0] quotient_r;
  logic [31:0] remainder_r;
  logic        busy_r;
  logic        done_r;
  logic        dbz_r;

  // 33-bit trial subtraction a - b as a + ~b + 1; bit 32 set means borrow
  function automatic logic [32:0] trial_sub(input logic [31:0] a, input logic [31:0] b);
    trial_sub = {1'b0, a} + {1'b1, ~b} + 33'd1;
  endfunction

  // A start is honoured only when no division is in flight
  assign accept_s = bus.start && ((state_r == IDLE) || (state_r == DONE));
  // Results are captured on the final RUN step
  assign load_s   = (state_r == RUN) && (state_nxt_s == DONE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_nxt_s = RUN;
        else           state_nxt_s = IDLE;
      end
      RUN: begin
        if (cnt_r == 5'd31) state_nxt_s = DONE;
        else                state_nxt_s = RUN;
      end
      DONE: begin
        if (bus.start) state_nxt_s = RUN;
        else           state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // One restoring step: shift in next dividend bit, keep trial if no borrow
  always_comb begin
    shifted_s = {rem_r[30:0], dq_r[31]};
    trial_s   = trial_sub(shifted_s, dv_r);
    if (trial_s[32] == 1'b0) begin
      rem_step_s = trial_s[31:0];
      dq_step_s  = {dq_r[30:0], 1'b1};
    end else begin
      rem_step_s = shifted_s;
      dq_step_s  = {dq_r[30:0], 1'b0};
    end
  end

  // Operand capture on accept, iteration while running
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dq_r  <= 32'd0;
      dv_r  <= 32'd0;
      rem_r <= 32'd0;
      cnt_r <= 5'd0;
    end else if (accept_s) begin
      dq_r  <= bus.dividend;
      dv_r  <= bus.divisor;
      rem_r <= 32'd0;
      cnt_r <= 5'd0;
    end else if (state_r == RUN) begin
      dq_r  <= dq_step_s;
      rem_r <= rem_step_s;
      cnt_r <= cnt_r + 5'd1;
    end else begin
      dq_r  <= dq_r;
      dv_r  <= dv_r;
      rem_r <= rem_r;
      cnt_r <= cnt_r;
    end
  end

  // Output decode: status follows the state being entered
  always_comb begin
    busy_nxt_s = (state_nxt_s == RUN);
    done_nxt_s = (state_nxt_s == DONE);
    if (accept_s) begin
      dbz_nxt_s = 1'b0;
    end else if (load_s) begin
      dbz_nxt_s = (dv_r == 32'd0);
    end else begin
      dbz_nxt_s = dbz_r;
    end
  end

  // Registered outputs; results change only when DONE is entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient_r  <= 32'd0;
      remainder_r <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      dbz_r  <= dbz_nxt_s;
      if (load_s) begin
        quotient_r  <= dq_step_s;
        remainder_r <= rem_step_s;
      end else begin
        quotient_r  <= quotient_r;
        remainder_r <= remainder_r;
      end
    end
  end

  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: doc/divu32.md
# divu32

Sequential 32-bit unsigned restoring divider for the alu32 datapath. It is the inverse operation to the adder chain: each step is a trial subtraction, formed as an add of the complement with carry-in 1. It takes dividend and divisor on a start strobe, iterates one quotient bit per clock, and returns quotient and remainder with a one-cycle done pulse. It sits beside the combinational ALU as a multi-cycle functional unit.

## Interface
- No parameters; width fixed at 32.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- dividend  input  32  unsigned dividend; captured on accepted start.
- divisor  input  32  unsigned divisor; captured on accepted start.
- quotient  output  32  result quotient; valid from done, held until next accepted start.
- remainder  output  32  result remainder; same validity as quotient.
- busy  output  1  high while iterating (state RUN).
- done  output  1  single-cycle pulse when results become valid.
- div_by_zero  output  1  set with done when captured divisor was 0; held with results.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE; quotient, remainder, busy, done, div_by_zero all 0; internal registers and counter cleared.
- IDLE: start=1 → load dq=dividend, dv=divisor, rem=0, cnt=0, clear div_by_zero; go RUN. start=0 → stay.
- RUN, per cycle:
  - shifted = {rem[30:0], dq[31]}; dq <<= 1.
  - trial = {1'b0,shifted} + {1'b1,~dv} + 1 (33-bit).
  - trial[32]=0 (no borrow) → rem=trial[31:0], dq[0]=1; else rem=shifted, dq[0]=0.
  - cnt increments; after the 32nd iteration (cnt=31) go DONE.
- DONE: done=1 for exactly this cycle; quotient=dq, remainder=rem, div_by_zero=(dv==0). start=1 in DONE → accepted as in IDLE (back-to-back); otherwise go IDLE.
- Divisor 0: no special path; the algorithm naturally yields quotient=32'hFFFF_FFFF, remainder=dividend; div_by_zero=1.
- start while busy: ignored; inputs not resampled; operation in progress unaffected.
- dividend/divisor changing after acceptance: no effect.
- Output registers update only at DONE entry; they hold the previous results through IDLE and the next RUN.
- Reset mid-RUN: immediate abort to IDLE, all outputs 0; next start behaves normally.

## Timing
- Accept edge E (start=1 sampled in IDLE/DONE): busy=1 after E.
- 32 RUN cycles: edges E+1 … E+32.
- After edge E+32: state DONE, busy=0, done=1, results valid.
- After edge E+33: done=0.
- Latency from accept edge to done high: 32 cycles; throughput one division per 33 cycles with back-to-back start.
- busy and done are never high together.
- All outputs are registered; there are no combinational input→output paths.

## Test plan
- 100 / 7: start pulse → busy 32 cycles, done one cycle at accept+32, quotient=14, remainder=2, div_by_zero=0.
- 32'hFFFF_FFFF / 1 and 5 / 32'hFFFF_FFFF → (FFFF_FFFF, 0) and (0, 5); 32'h8000_0000 / 32'h8000_0000 → (1, 0).
- 1234 / 0 → quotient=32'hFFFF_FFFF, remainder=1234, div_by_zero=1 at done; next 9/3 → (3, 0), div_by_zero cleared.
- Start 50/4, then pulse start with 99/9 at cycle 10 of RUN → ignored; result (12, 2) at the original done time; busy unaffected.
- Start held high across DONE with new operands 77/10 → second accept at the DONE cycle, second done exactly 33 cycles after the first, result (7, 7).
- Assert reset at RUN cycle 15 → busy, done, quotient, remainder, div_by_zero all 0 asynchronously; after release, 20/6 → (3, 2) with normal latency.
- Randomized: 1000 operand pairs including 0 and all-ones; compare against the / and % reference model.
